bus1ton: RTL and testbench
==========================

Name: bus1ton

Overview:
- Parametrised successor to the 1-to-2 combinational bus splitter.
- Connects one valid/ready master port to N slave ports. Decode uses base/mask windows.
- Request is registered for one transaction at a time. Unmapped accesses and stalled slaves get an error response instead of hanging.
- Sits between the core's data port and the peripheral and memory slaves.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- S_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, flattened N*32 base addresses. Slave i is at bits [32*i+:32].
- S_MASK, {4{32'hF000_0000}}, flattened N*32 decode masks. Slave i hits when (addr & mask_i) == base_i.
- TIMEOUT, 255, cycles a selected slave may stall before an error response. 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, m_rdata value returned on an error response.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- m_valid  input  1  master request valid, held until m_ready.
- m_ready  output  1  one-cycle response strobe.
- m_addr  input  32  request address.
- m_wdata  input  32  write data.
- m_wstrb  input  4  byte strobes; 0 means read.
- m_rdata  output  32  read data, valid when m_ready=1.
- m_err  output  1  error flag, valid when m_ready=1.
- s_valid  output  N_SLAVES  per-slave request valid, one-hot or zero.
- s_ready  input  N_SLAVES  per-slave ready.
- s_addr  output  32  registered address, broadcast to all slaves.
- s_wdata  output  32  registered write data, broadcast.
- s_wstrb  output  4  registered strobes, broadcast.
- s_rdata  input  N_SLAVES*32  per-slave read data; slave i is at bits [32*i+:32].

Behaviour:
- Reset (async, active-high): state=IDLE; s_valid=0, m_ready=0, m_err=0, m_rdata=0, s_addr/s_wdata/s_wstrb=0, timeout counter=0. Reset mid-transaction abandons the transaction silently.
- Decode: hit_i = ((m_addr & mask_i) == base_i). When windows overlap, the lowest index wins. No hit means unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, m_valid=1 and hit: latch m_addr/m_wdata/m_wstrb into s_addr/s_wdata/s_wstrb and latch sel=winning index; clear the counter; next state ACCESS.
- IDLE, m_valid=1 and unmapped: load m_rdata=ERR_RDATA, m_err=1; next state RESP. No s_valid is asserted.
- ACCESS: s_valid[sel]=1, all other bits 0. The counter increments every cycle.
  - On s_ready[sel]=1: capture s_rdata[sel] into m_rdata, set m_err=0, drop s_valid at the next edge, go to RESP.
  - s_ready of unselected slaves is ignored.
- ACCESS timeout (TIMEOUT!=0): when counter==TIMEOUT-1 and s_ready[sel]=0, drop s_valid, set m_rdata=ERR_RDATA and m_err=1, go to RESP.
  - If s_ready[sel] and the timeout coincide in the same cycle, ready wins and the response is normal.
- RESP: m_ready=1 for exactly one cycle, then go to IDLE. m_ready is registered, not combinational from s_ready.
- m_rdata and m_err hold their value until the next response is loaded.
- Latency:
  - Mapped access: request accepted at edge 0; s_valid high during cycle 1; slave ready in cycle k≥1; m_ready during cycle k+1.
  - Zero-wait-state slave: 2-cycle turnaround.
  - Unmapped access: m_ready in cycle 1.
- IDLE samples m_valid only. The master drops m_valid at the edge ending the m_ready cycle, so no duplicate accept occurs.
- If m_valid drops during ACCESS (protocol violation), it is ignored and the transaction completes.
- Counter width is $clog2(TIMEOUT+1). It saturates rather than wraps.
- Write vs read: the block is agnostic. s_rdata is captured on writes too; the master ignores it.

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - BUS_AW=32, BUS_DW=32, BUS_SW=4;
  - default ERR_RDATA constant.
- One sub-module, bus_addr_decoder:
  - purely combinational;
  - parameters N_SLAVES, S_BASE, S_MASK;
  - outputs hit (1) and sel index ($clog2(N_SLAVES) bits, lowest-index priority).
- The FSM, counter and data registers live in bus1ton.

Test Plan:
- Read, zero-wait slave 1: m_addr=32'h1000_0040, s_ready[1] tied 1, s_rdata[1]=32'h1234_5678 -> s_valid=4'b0010 for 1 cycle, s_addr=32'h1000_0040, m_ready 2 cycles after accept, m_rdata=32'h1234_5678, m_err=0.
- Write, wait states slave 3: m_addr=32'h3000_0004, m_wdata=32'hCAFE_0001, m_wstrb=4'hF, s_ready[3] after 5 cycles -> s_valid[3] high exactly 5 cycles, s_wdata/s_wstrb stable throughout, one m_ready pulse, m_err=0.
- Unmapped: override mask/base so 32'h8000_0000 misses -> no s_valid bit ever set, m_ready in cycle 1, m_rdata=32'hDEAD_BEEF, m_err=1.
- Timeout: TIMEOUT=8, slave 2 never ready -> s_valid[2] high exactly 8 cycles then 0, m_ready with m_err=1 and ERR_RDATA. With s_ready[2] asserted in the 8th cycle instead -> normal response, m_err=0.
- Overlap and isolation: slaves 0 and 1 both match 32'h0000_0100 -> only s_valid[0]. Toggling s_ready[2] during the access has no effect.
- Reset mid-ACCESS: assert rst while s_valid[1]=1 -> all outputs 0 asynchronously. After release with m_valid=0 the block stays IDLE; a new request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus1ton splitter
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    localparam logic [BUS_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - base/mask window decoder, lowest index wins
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                         N_SLAVES = 4,
    parameter logic [N_SLAVES*BUS_AW-1:0] S_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*BUS_AW-1:0] S_MASK   = {4{32'hF000_0000}},
    localparam int                        SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [BUS_AW-1:0] addr_i,
    output logic              hit_o,
    output logic [SEL_W-1:0]  sel_o
);

    // Scan from the top index down so the lowest matching window is the last assignment.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & S_MASK[BUS_AW*i +: BUS_AW]) == S_BASE[BUS_AW*i +: BUS_AW]) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus1ton.sv
// rtl/bus1ton.sv - registered 1-to-N valid/ready bus splitter with error responses
module bus1ton
    import bus_pkg::*;
#(
    parameter int                         N_SLAVES  = 4,
    parameter logic [N_SLAVES*BUS_AW-1:0] S_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                       32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*BUS_AW-1:0] S_MASK    = {4{32'hF000_0000}},
    parameter int                         TIMEOUT   = 255,
    parameter logic [BUS_DW-1:0]          ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [BUS_AW-1:0]          m_addr,
    input  logic [BUS_DW-1:0]          m_wdata,
    input  logic [BUS_SW-1:0]          m_wstrb,
    output logic [BUS_DW-1:0]          m_rdata,
    output logic                       m_err,
    output logic [N_SLAVES-1:0]        s_valid,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic [BUS_AW-1:0]          s_addr,
    output logic [BUS_DW-1:0]          s_wdata,
    output logic [BUS_SW-1:0]          s_wstrb,
    input  logic [N_SLAVES*BUS_DW-1:0] s_rdata
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // A zero TIMEOUT still needs a legal one-bit counter; it just never fires.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_AW-1:0]  s_addr_q, s_addr_d;
    logic [BUS_DW-1:0]  s_wdata_q, s_wdata_d;
    logic [BUS_SW-1:0]  s_wstrb_q, s_wstrb_d;
    logic [BUS_DW-1:0]  m_rdata_q, m_rdata_d;
    logic               m_err_q, m_err_d;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic [BUS_DW-1:0]  rdata_arr [N_SLAVES];

    bus_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .S_BASE   (S_BASE),
        .S_MASK   (S_MASK)
    ) u_dec (
        .addr_i (m_addr),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel)
    );

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_rdata
        assign rdata_arr[g] = s_rdata[BUS_DW*g +: BUS_DW];
    end

    // Next-state: accept in IDLE, wait for the selected slave or the timeout, pulse the response.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (dec_hit) begin
                        s_addr_d  = m_addr;
                        s_wdata_d = m_wdata;
                        s_wstrb_d = m_wstrb;
                        sel_d     = dec_sel;
                        cnt_d     = '0;
                        state_d   = ACCESS;
                    end else begin
                        m_rdata_d = ERR_RDATA;
                        m_err_d   = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Ready is checked first so a ready arriving on the timeout cycle still completes normally.
                if (s_ready[sel_q]) begin
                    m_rdata_d = rdata_arr[sel_q];
                    m_err_d   = 1'b0;
                    state_d   = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    m_rdata_d = ERR_RDATA;
                    m_err_d   = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
        end
    end

    assign s_valid = (state_q == ACCESS) ? (N_SLAVES'(1) << sel_q) : '0;
    assign m_ready = (state_q == RESP);
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wstrb = s_wstrb_q;
    assign m_rdata = m_rdata_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_bus1ton.sv
// tb/tb_bus1ton.sv - self-checking bench for bus1ton
module tb_bus1ton;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    // Slaves 0 and 1 overlap on 0x0xxx_xxxx; 0x4000_0000 and above is unmapped.
    localparam logic [N*32-1:0] P_BASE = {32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] P_MASK = {32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hF000_0000};

    logic [31:0] base_m [N] = '{32'h0000_0000, 32'h0000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] mask_m [N] = '{32'hF000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000};

    logic            clk = 1'b0;
    logic            rst;
    logic            m_valid;
    logic            m_ready;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [3:0]      m_wstrb;
    logic [31:0]     m_rdata;
    logic            m_err;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [N*32-1:0] s_rdata;

    int errors = 0;
    int checks = 0;

    bus1ton #(
        .N_SLAVES  (N),
        .S_BASE    (P_BASE),
        .S_MASK    (P_MASK),
        .TIMEOUT   (TO),
        .ERR_RDATA (ERR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & mask_m[i]) == base_m[i]) return i;
        end
        return -1;
    endfunction

    // lat = ACCESS cycle in which the selected slave raises ready (0 = never).
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lat, input logic [31:0] sel_rd);
        int          sel;
        int          n_valid;
        int          resp_cyc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] rd [N];
        logic [N-1:0] exp_v;

        sel = model_sel(addr);
        for (int i = 0; i < N; i++) rd[i] = $urandom;
        if (sel >= 0) rd[sel] = sel_rd;

        if (sel < 0) begin
            n_valid = 0;  resp_cyc = 1;      exp_rd = ERR;     exp_err = 1'b1;
        end else if (lat >= 1 && lat <= TO) begin
            n_valid = lat; resp_cyc = lat + 1; exp_rd = rd[sel]; exp_err = 1'b0;
        end else begin
            n_valid = TO; resp_cyc = TO + 1; exp_rd = ERR;     exp_err = 1'b1;
        end

        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        s_ready = '0;
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = rd[i];

        for (int c = 1; c <= resp_cyc; c++) begin
            @(negedge clk);
            exp_v = (sel >= 0 && c <= n_valid) ? N'(1 << sel) : '0;
            check($sformatf("%s s_valid c%0d", tag, c), 32'(s_valid), 32'(exp_v));
            check($sformatf("%s m_ready c%0d", tag, c), 32'(m_ready), 32'(c == resp_cyc));
            if (c <= n_valid) begin
                check($sformatf("%s s_addr c%0d", tag, c), s_addr, addr);
                check($sformatf("%s s_wdata c%0d", tag, c), s_wdata, wdata);
                check($sformatf("%s s_wstrb c%0d", tag, c), 32'(s_wstrb), 32'(wstrb));
            end
            if (c == resp_cyc) begin
                check({tag, " m_rdata"}, m_rdata, exp_rd);
                check({tag, " m_err"}, 32'(m_err), 32'(exp_err));
                m_valid = 1'b0;
                s_ready = '0;
            end else begin
                s_ready = N'($urandom);
                if (sel >= 0) s_ready[sel] = (c == lat);
            end
        end

        @(negedge clk);
        check({tag, " m_ready after"}, 32'(m_ready), 32'd0);
        check({tag, " s_valid after"}, 32'(s_valid), 32'd0);
        check({tag, " m_rdata hold"}, m_rdata, exp_rd);
        check({tag, " m_err hold"}, 32'(m_err), 32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " s_valid"}, 32'(s_valid), 32'd0);
        check({tag, " m_ready"}, 32'(m_ready), 32'd0);
        check({tag, " m_err"}, 32'(m_err), 32'd0);
        check({tag, " m_rdata"}, m_rdata, 32'd0);
        check({tag, " s_addr"}, s_addr, 32'd0);
        check({tag, " s_wdata"}, s_wdata, 32'd0);
        check({tag, " s_wstrb"}, 32'(s_wstrb), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          region;

        rst     = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_txn("rd_s1_zw",   32'h1000_0040, 32'h0,          4'h0, 1, 32'h1234_5678);
        run_txn("wr_s3_ws",   32'h3000_0004, 32'hCAFE_0001,  4'hF, 5, $urandom);
        run_txn("unmapped",   32'h8000_0000, 32'h0,          4'h0, 1, $urandom);
        run_txn("timeout",    32'h2000_0010, 32'h0,          4'h0, 0, $urandom);
        run_txn("to_race",    32'h2000_0020, 32'h5555_AAAA,  4'h3, TO, 32'hA5A5_0008);
        run_txn("overlap",    32'h0000_0100, 32'h0,          4'h0, 3, 32'h0BAD_F00D);

        // Reset while slave 1 is being accessed.
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h1000_0080;
        m_wdata = 32'h1111_2222;
        m_wstrb = 4'h1;
        s_ready = '0;
        @(negedge clk);
        check("rst_mid s_valid before", 32'(s_valid), 32'h2);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid async");
        @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_idle s_valid %0d", i), 32'(s_valid), 32'd0);
            check($sformatf("rst_idle m_ready %0d", i), 32'(m_ready), 32'd0);
        end
        run_txn("post_rst", 32'h1000_0044, 32'h0, 4'h0, 2, 32'hFEED_0001);

        for (int t = 0; t < 40; t++) begin
            region = $urandom_range(0, 4);
            a = $urandom;
            if (region < 4) a[31:28] = 4'(region);
            run_txn($sformatf("rnd%0d", t), a, $urandom, 4'($urandom), $urandom_range(0, 10), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
